// File: rtl/datapath_acc_if.sv
// Operand/strobe bundle from the control unit into the accumulator datapath,
// plus the status values returned to the debug side.
interface datapath_acc_if #(
   parameter int unsigned BITS    = 16,
   parameter int unsigned DTBITS  = BITS - 5,
   parameter int unsigned CNTBITS = 32
);
   logic [DTBITS-1:0]  i_Data;
   logic [1:0]         i_sel_A;
   logic               i_sel_B;
   logic               i_op;
   logic               i_w_acc;
   logic               i_w_ram;
   logic               i_r_ram;
   logic               i_h_flg;
   logic [BITS-1:0]    o_acc;
   logic               o_halted;
   logic [CNTBITS-1:0] o_cnt;

   // Control unit side.
   modport master (
      output i_Data, i_sel_A, i_sel_B, i_op, i_w_acc, i_w_ram, i_r_ram, i_h_flg,
      input  o_acc, o_halted, o_cnt
   );

   // Datapath side.
   modport slave (
      input  i_Data, i_sel_A, i_sel_B, i_op, i_w_acc, i_w_ram, i_r_ram, i_h_flg,
      output o_acc, o_halted, o_cnt
   );
endinterface

// File: rtl/datapath_acc.sv
// Accumulator datapath: accumulator, single-port data RAM, add/sub ALU,
// sticky halt and saturating executed-instruction counter.
module datapath_acc #(
   parameter int unsigned BITS    = 16,
   parameter int unsigned DTBITS  = BITS - 5,
   parameter int unsigned RAM_AW  = 6,
   parameter int unsigned CNTBITS = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   datapath_acc_if.slave bus
);

   typedef enum logic {StRun, StHalt} state_e;

   state_e               state_q, state_d;
   logic [BITS-1:0]      acc_q, acc_d;
   logic [CNTBITS-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0]      mem_q [2**RAM_AW];

   logic [RAM_AW-1:0]    addr;
   logic [BITS-1:0]      imm;
   logic [BITS-1:0]      rd;
   logic [BITS-1:0]      alu_b;
   logic [BITS-1:0]      res;
   logic                 acc_we;
   logic                 ram_we;
   logic                 cnt_en;

   assign addr  = bus.i_Data[RAM_AW-1:0];
   assign imm   = {{(BITS - DTBITS){bus.i_Data[DTBITS-1]}}, bus.i_Data};
   // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
   assign rd    = bus.i_r_ram ? mem_q[addr] : '0;
   assign alu_b = bus.i_sel_B ? imm : rd;
   assign res   = bus.i_op ? (acc_q - alu_b) : (acc_q + alu_b);

   // Halt FSM: the halting edge and every edge in HALT suppress all writes.
   always_comb begin
      state_d = state_q;
      acc_we  = 1'b0;
      ram_we  = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         StRun: begin
            cnt_en = 1'b1;
            if (bus.i_h_flg) begin
               state_d = StHalt;
            end else begin
               acc_we = bus.i_w_acc;
               ram_we = bus.i_w_ram;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // Accumulator source select.
   always_comb begin
      acc_d = acc_q;
      if (acc_we) begin
         case (bus.i_sel_A)
            2'b00:   acc_d = rd;
            2'b01:   acc_d = imm;
            2'b10:   acc_d = res;
            default: acc_d = acc_q;
         endcase
      end
   end

   // Counter holds at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNTBITS'(1);
      end
   end

   // State, accumulator and counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StRun;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Data RAM; cleared in a single reset cycle, writes store the pre-edge acc.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_q <= '{default: '0};
      end else if (ram_we) begin
         mem_q[addr] <= acc_q;
      end
   end

   assign bus.o_acc    = acc_q;
   assign bus.o_halted = (state_q == StHalt);
   assign bus.o_cnt    = cnt_q;

endmodule
